// File: rtl/spi_ram_slave_p.sv
// SPI slave front-end driving a single-port RAM with separate write/read
// address registers, optional burst auto-increment and frame-abort flag.
module spi_ram_slave_p #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int MEM_DEPTH  = 256,
  parameter int AUTO_INC   = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic SS_n,
  input  logic MOSI,
  output logic MISO,
  output logic frame_err
);

  localparam int PW = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  localparam int W  = PW + 2;
  localparam int CW = $clog2(W) + 1;
  localparam int IW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  localparam logic [ADDR_WIDTH:0] DEPTH    = (ADDR_WIDTH+1)'(MEM_DEPTH);
  localparam logic [ADDR_WIDTH:0] DEPTH_M1 = (ADDR_WIDTH+1)'(MEM_DEPTH-1);

  typedef enum logic [2:0] {IDLE, RX, EXEC, TX, DONE} state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [W-1:0]          rx_q, rx_d;
  logic [DATA_WIDTH-1:0] tx_q, tx_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic                  miso_q, miso_d;
  logic                  ferr_q, ferr_d;
  logic                  mem_we;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  logic [1:0]            cmd;
  logic [ADDR_WIDTH-1:0] pl_addr;
  logic [DATA_WIDTH-1:0] pl_data;
  logic                  wr_ok, rd_ok;
  logic [ADDR_WIDTH-1:0] wr_inc, rd_inc;
  logic [DATA_WIDTH-1:0] rd_word;

  assign cmd     = rx_q[W-1:W-2];
  assign pl_addr = rx_q[ADDR_WIDTH-1:0];
  assign pl_data = rx_q[DATA_WIDTH-1:0];

  assign wr_ok = {1'b0, wr_addr_q} < DEPTH;
  assign rd_ok = {1'b0, rd_addr_q} < DEPTH;

  // Last implemented word and anything out of range both wrap to 0.
  assign wr_inc = ({1'b0, wr_addr_q} >= DEPTH_M1) ? '0
                : wr_addr_q + ADDR_WIDTH'(1);
  assign rd_inc = ({1'b0, rd_addr_q} >= DEPTH_M1) ? '0
                : rd_addr_q + ADDR_WIDTH'(1);

  assign rd_word = rd_ok ? mem[rd_addr_q[IW-1:0]] : '0;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rx_d      = rx_q;
    tx_d      = tx_q;
    wr_addr_d = wr_addr_q;
    rd_addr_d = rd_addr_q;
    miso_d    = 1'b0;
    ferr_d    = 1'b0;
    mem_we    = 1'b0;
    if (SS_n) begin
      state_d = IDLE;
      cnt_d   = '0;
      ferr_d  = (state_q == RX);
    end else begin
      unique case (state_q)
        IDLE: begin
          rx_d    = {{(W-1){1'b0}}, MOSI};
          cnt_d   = CW'(1);
          state_d = RX;
        end
        RX: begin
          rx_d  = {rx_q[W-2:0], MOSI};
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(W-1))
            state_d = EXEC;
        end
        EXEC: begin
          cnt_d   = '0;
          state_d = DONE;
          unique case (cmd)
            2'b00: wr_addr_d = pl_addr;
            2'b01: begin
              mem_we = wr_ok;
              if (AUTO_INC != 0)
                wr_addr_d = wr_inc;
            end
            2'b10: rd_addr_d = pl_addr;
            2'b11: begin
              tx_d    = rd_word;
              state_d = TX;
              if (AUTO_INC != 0)
                rd_addr_d = rd_inc;
            end
            default: ;
          endcase
        end
        TX: begin
          miso_d = tx_q[DATA_WIDTH-1];
          tx_d   = tx_q << 1;
          cnt_d  = cnt_q + CW'(1);
          if (cnt_q == CW'(DATA_WIDTH-1))
            state_d = DONE;
        end
        DONE: ;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rx_q      <= '0;
      tx_q      <= '0;
      wr_addr_q <= '0;
      rd_addr_q <= '0;
      miso_q    <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rx_q      <= rx_d;
      tx_q      <= tx_d;
      wr_addr_q <= wr_addr_d;
      rd_addr_q <= rd_addr_d;
      miso_q    <= miso_d;
      ferr_q    <= ferr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && mem_we)
      mem[wr_addr_q[IW-1:0]] <= pl_data;
  end

  assign MISO      = miso_q;
  assign frame_err = ferr_q;

endmodule

// File: tb/tb_spi_ram_slave_p.sv
// Bench for spi_ram_slave_p: default, shallow (200-word) and
// no-increment instances against directed vectors and a memory model.
module tb_spi_ram_slave_p;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] ss_n;
  logic [2:0] mosi;
  logic [2:0] miso;
  logic [2:0] ferr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  spi_ram_slave_p u0 (
    .clk(clk), .rst(rst), .SS_n(ss_n[0]), .MOSI(mosi[0]),
    .MISO(miso[0]), .frame_err(ferr[0])
  );

  spi_ram_slave_p #(.MEM_DEPTH(200)) u1 (
    .clk(clk), .rst(rst), .SS_n(ss_n[1]), .MOSI(mosi[1]),
    .MISO(miso[1]), .frame_err(ferr[1])
  );

  spi_ram_slave_p #(.AUTO_INC(0)) u2 (
    .clk(clk), .rst(rst), .SS_n(ss_n[2]), .MOSI(mosi[2]),
    .MISO(miso[2]), .frame_err(ferr[2])
  );

  // Reference: plain arrays of words and two address counters per instance.
  logic [7:0] mem_m [3][256];
  bit         known [3][256];
  int         wr_m [3];
  int         rd_m [3];
  int         depth_m [3] = '{256, 200, 256};
  bit         ai_m [3]    = '{1'b1, 1'b1, 1'b0};

  typedef struct {
    int         d;
    logic [1:0] cmd;
    logic [7:0] pl;
    logic [7:0] exp;
    bit         chk;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int bump(input int a, input int depth);
    return (a + 1 >= depth) ? 0 : a + 1;
  endfunction

  task automatic model(input int d, input logic [1:0] cmd,
                       input logic [7:0] pl, output logic [7:0] exp,
                       output bit valid);
    exp   = 8'h00;
    valid = 1'b0;
    case (cmd)
      2'd0: wr_m[d] = int'(pl);
      2'd1: begin
        if (wr_m[d] < depth_m[d]) begin
          mem_m[d][wr_m[d]] = pl;
          known[d][wr_m[d]] = 1'b1;
        end
        if (ai_m[d]) wr_m[d] = bump(wr_m[d], depth_m[d]);
      end
      2'd2: rd_m[d] = int'(pl);
      default: begin
        if (rd_m[d] >= depth_m[d]) begin
          exp   = 8'h00;
          valid = 1'b1;
        end else begin
          exp   = mem_m[d][rd_m[d]];
          valid = known[d][rd_m[d]];
        end
        if (ai_m[d]) rd_m[d] = bump(rd_m[d], depth_m[d]);
      end
    endcase
  endtask

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      wr_m[d] = 0;
      rd_m[d] = 0;
    end
  endtask

  // One complete frame; starts and ends at a falling edge.
  task automatic frame(input int d, input logic [1:0] cmd,
                       input logic [7:0] pl, output logic [7:0] rdata);
    logic [9:0] w;
    int fe;
    w     = {cmd, pl};
    fe    = 0;
    rdata = 8'h00;
    ss_n[d] = 1'b0;
    for (int k = 0; k < 10; k++) begin
      mosi[d] = w[9-k];
      @(negedge clk);
      fe += int'(ferr[d]);
    end
    mosi[d] = 1'b0;
    @(negedge clk);
    fe += int'(ferr[d]);
    if (cmd == 2'd3) begin
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        rdata[7-i] = miso[d];
        fe += int'(ferr[d]);
      end
    end
    @(negedge clk);
    check($sformatf("miso_done_d%0d", d), 32'(miso[d]), 32'd0);
    ss_n[d] = 1'b1;
    @(negedge clk);
    fe += int'(ferr[d]);
    check($sformatf("ferr_full_frame_d%0d", d), 32'(fe), 32'd0);
  endtask

  function automatic vec_t mk(input int d, input logic [1:0] cmd,
                              input logic [7:0] pl, input logic [7:0] exp,
                              input bit chk);
    vec_t v;
    v.d = d; v.cmd = cmd; v.pl = pl; v.exp = exp; v.chk = chk;
    return v;
  endfunction

  initial begin
    logic [7:0] r, me;
    logic [9:0] w;
    logic [2:0] part;
    logic [2:0] part_exp;
    bit         mv;
    int         fe_cnt;
    logic [1:0] cmd;
    logic [7:0] pl;
    int         d;

    model_reset();

    // basic write/read; burst wrap; shallow memory; held address
    vecs.push_back(mk(0, 2'd0, 8'h12, 8'h00, 0));
    vecs.push_back(mk(0, 2'd1, 8'hA5, 8'h00, 0));
    vecs.push_back(mk(0, 2'd2, 8'h12, 8'h00, 0));
    vecs.push_back(mk(0, 2'd3, 8'h00, 8'hA5, 1));
    vecs.push_back(mk(0, 2'd0, 8'hFF, 8'h00, 0));
    vecs.push_back(mk(0, 2'd1, 8'h11, 8'h00, 0));
    vecs.push_back(mk(0, 2'd1, 8'h22, 8'h00, 0));
    vecs.push_back(mk(0, 2'd2, 8'hFF, 8'h00, 0));
    vecs.push_back(mk(0, 2'd3, 8'h00, 8'h11, 1));
    vecs.push_back(mk(0, 2'd3, 8'h00, 8'h22, 1));
    vecs.push_back(mk(0, 2'd2, 8'h12, 8'h00, 0));
    vecs.push_back(mk(0, 2'd3, 8'h00, 8'hA5, 1));
    vecs.push_back(mk(1, 2'd0, 8'hC8, 8'h00, 0));
    vecs.push_back(mk(1, 2'd1, 8'h77, 8'h00, 0));
    vecs.push_back(mk(1, 2'd2, 8'hC8, 8'h00, 0));
    vecs.push_back(mk(1, 2'd3, 8'h00, 8'h00, 1));
    vecs.push_back(mk(1, 2'd0, 8'hC7, 8'h00, 0));
    vecs.push_back(mk(1, 2'd1, 8'h01, 8'h00, 0));
    vecs.push_back(mk(1, 2'd1, 8'h02, 8'h00, 0));
    vecs.push_back(mk(1, 2'd2, 8'hC7, 8'h00, 0));
    vecs.push_back(mk(1, 2'd3, 8'h00, 8'h01, 1));
    vecs.push_back(mk(1, 2'd3, 8'h00, 8'h02, 1));
    vecs.push_back(mk(2, 2'd0, 8'h05, 8'h00, 0));
    vecs.push_back(mk(2, 2'd1, 8'h5A, 8'h00, 0));
    vecs.push_back(mk(2, 2'd2, 8'h05, 8'h00, 0));
    vecs.push_back(mk(2, 2'd3, 8'h00, 8'h5A, 1));
    vecs.push_back(mk(2, 2'd3, 8'h00, 8'h5A, 1));
    vecs.push_back(mk(2, 2'd1, 8'h6B, 8'h00, 0));
    vecs.push_back(mk(2, 2'd3, 8'h00, 8'h6B, 1));

    rst  = 1'b1;
    ss_n = 3'b111;
    mosi = 3'b000;
    repeat (3) @(negedge clk);
    check("reset_miso", 32'(miso), 32'd0);
    check("reset_ferr", 32'(ferr), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    foreach (vecs[i]) begin
      frame(vecs[i].d, vecs[i].cmd, vecs[i].pl, r);
      model(vecs[i].d, vecs[i].cmd, vecs[i].pl, me, mv);
      if (vecs[i].chk)
        check($sformatf("vec%0d_read", i), 32'(r), 32'(vecs[i].exp));
    end

    // abort after 5 bits of a write
    frame(0, 2'd0, 8'h40, r); model(0, 2'd0, 8'h40, me, mv);
    frame(0, 2'd1, 8'h99, r); model(0, 2'd1, 8'h99, me, mv);
    frame(0, 2'd0, 8'h40, r); model(0, 2'd0, 8'h40, me, mv);
    w = {2'b01, 8'h3C};
    ss_n[0] = 1'b0;
    for (int k = 0; k < 5; k++) begin
      mosi[0] = w[9-k];
      @(negedge clk);
    end
    ss_n[0] = 1'b1;
    @(negedge clk);
    check("abort_ferr_high", 32'(ferr[0]), 32'd1);
    fe_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      fe_cnt += int'(ferr[0]);
    end
    check("abort_ferr_width", 32'(fe_cnt), 32'd0);
    frame(0, 2'd2, 8'h40, r); model(0, 2'd2, 8'h40, me, mv);
    frame(0, 2'd3, 8'h00, r); model(0, 2'd3, 8'h00, me, mv);
    check("abort_mem_kept", 32'(r), 32'h99);
    frame(0, 2'd1, 8'h3C, r); model(0, 2'd1, 8'h3C, me, mv);
    frame(0, 2'd2, 8'h40, r); model(0, 2'd2, 8'h40, me, mv);
    frame(0, 2'd3, 8'h00, r); model(0, 2'd3, 8'h00, me, mv);
    check("after_abort_write", 32'(r), 32'h3C);

    // reset during bit 3 of a read
    frame(0, 2'd2, 8'h40, r); model(0, 2'd2, 8'h40, me, mv);
    part_exp = mem_m[0][rd_m[0]][7:5];
    w = {2'b11, 8'h00};
    ss_n[0] = 1'b0;
    for (int k = 0; k < 10; k++) begin
      mosi[0] = w[9-k];
      @(negedge clk);
    end
    mosi[0] = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      part[2-i] = miso[0];
    end
    check("pre_reset_bits", 32'(part), 32'(part_exp));
    rst     = 1'b1;
    ss_n[0] = 1'b1;
    @(negedge clk);
    check("rst_tx_miso", 32'(miso[0]), 32'd0);
    check("rst_tx_ferr", 32'(ferr[0]), 32'd0);
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    check("rst_idle_miso", 32'(miso[0]), 32'd0);
    frame(0, 2'd3, 8'h00, r); model(0, 2'd3, 8'h00, me, mv);
    check("rst_rd_addr_zero", 32'(r), 32'h22);

    // random traffic against the model
    for (int n = 0; n < 400; n++) begin
      d   = $urandom_range(0, 2);
      cmd = 2'($urandom_range(0, 3));
      if (cmd == 2'd0 || cmd == 2'd2)
        pl = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(190, 255))
                                         : 8'($urandom_range(0, 15));
      else
        pl = 8'($urandom);
      frame(d, cmd, pl, r);
      model(d, cmd, pl, me, mv);
      if (cmd == 2'd3 && mv)
        check($sformatf("rand%0d_d%0d_read", n, d), 32'(r), 32'(me));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_ram_slave_p.md
Name: spi_ram_slave_p

Overview:
Parametrised SPI-slave-plus-single-port-RAM block, successor to the fixed 8-bit/256-word SPI/RAM pair. It is generalised in address width, data width and memory depth. New behaviour: optional address auto-increment for burst access, out-of-range protection, and frame-abort reporting. The SPI side is sampled on the system clock and the block is used as a self-contained register/memory port behind a single SPI chip select.

Parameters:
ADDR_WIDTH, 8, RAM address width in bits.
DATA_WIDTH, 8, RAM word width in bits.
MEM_DEPTH, 256, number of implemented words; must be ≤ 2^ADDR_WIDTH.
AUTO_INC, 1, 1 = post-increment the write/read address after each data op; 0 = address held.

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
SS_n  input  1  chip select, active-low, sampled on clk
MOSI  input  1  serial in, MSB first, one bit per clk while SS_n=0
MISO  output  1  serial out, MSB first, registered
frame_err  output  1  one-cycle pulse, frame aborted before complete

Behaviour:
- Interface: one clock, clk; synchronous active-high reset, rst.
- Frame length: W = 2 + PW, where PW = max(ADDR_WIDTH, DATA_WIDTH). With defaults, W = 10.
- Bits sampled at the first W rising edges with SS_n=0; edge index k = 0..W-1. Word bits [W-1:W-2] are the command. Address = payload[ADDR_WIDTH-1:0]; data = payload[DATA_WIDTH-1:0].
- Commands:
  - 00: load wr_addr.
  - 01: write data to mem[wr_addr].
  - 10: load rd_addr.
  - 11: read mem[rd_addr]; payload is don't-care.
- FSM states: IDLE, RX, EXEC, TX, DONE.
  - IDLE → RX on first edge with SS_n=0; bit 0 is captured on that edge.
  - RX → EXEC at edge W-1.
  - EXEC, at edge W: executes the command.
    - Address load or memory write completes here.
    - Read: the word is latched into the shift register.
    - Next state is TX for cmd 11, otherwise DONE.
  - TX: MISO carries data bit DATA_WIDTH-1-i in the cycle following edge W+1+i, for i = 0..DATA_WIDTH-1. After the last bit, go to DONE.
  - DONE: ignores MOSI and drives MISO=0 until SS_n=1. Only one frame is accepted per SS_n assertion.
- SS_n=1 sampled in any state: next state IDLE, bit counter cleared, MISO=0.
  - If in RX with 1..W-1 bits captured, frame_err=1 for exactly one cycle.
  - No command executes on an aborted frame. Addresses and memory are unchanged.
  - Abort during TX: no frame_err; the read and auto-increment have already happened.
- Out-of-range (address ≥ MEM_DEPTH):
  - Write is ignored.
  - Read returns all zeros.
- Auto-increment (AUTO_INC=1):
  - After cmd 01, wr_addr ← wr_addr+1.
  - After cmd 11, rd_addr ← rd_addr+1.
  - Value MEM_DEPTH-1, or any out-of-range value, wraps to 0.
  - Applied in EXEC, same edge as the access.
- wr_addr and rd_addr are independent registers.
- Reset (rst=1 at any edge, including mid-frame or mid-TX):
  - state IDLE, MISO=0, frame_err=0.
  - wr_addr=0, rd_addr=0; bit counter and shift registers cleared.
  - RAM contents are not cleared.
  - rst has priority over SS_n.
- Memory: single-port, synchronous. At most one access per frame, so there are no port conflicts.

Test Plan:
1. Defaults. Send frames 00_0x12, 01_0xA5, 10_0x12, 11_x, each with SS_n released between frames → MISO = 1,0,1,0,0,1,0,1 in the cycles after edges 11..18. frame_err stays 0.
2. Auto-increment wrap. Send 00_0xFF, 01_0x11, 01_0x22, 10_0xFF, 11, 11 → reads return 0x11 then 0x22, i.e. mem[0xFF]=0x11 and mem[0x00]=0x22.
3. Abort. Raise SS_n after 5 bits of 01_0x3C → frame_err high exactly 1 cycle, memory unchanged. The next full frame executes normally.
4. MEM_DEPTH=200.
   - 00_0xC8 then 01_0x77 → no write; a read of 0xC8 returns 0x00.
   - 00_0xC7, 01_0x01, 01_0x02 → mem[199]=0x01, mem[0]=0x02.
5. Reset mid-TX. Assert rst for 1 cycle during bit 3 of a read → MISO=0 the next cycle and state IDLE. A following 11 read returns mem[0] (rd_addr reset).
6. AUTO_INC=0. Send 10_0x05, then 11, 11 → both reads return mem[0x05]; rd_addr stays 0x05.
